// File: rtl/wb_arb_pkg.sv
// Shared widths and request type for the writeback arbiter.
// Round-robin arbitration is selected by defining WB_ARB_RR_EN.
package wb_arb_pkg;
    localparam int XLEN        = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int NUM_REQ_DEF = 3;
    // Pointer wide enough for the largest legal requester count (4).
    localparam int PTR_W       = 2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;
endpackage

// File: rtl/wb_arb_pick.sv
// Combinational grant picker: first valid index scanning cyclically from ptr.
module wb_arb_pick
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants one requester per cycle into a registered
// register-file write port. Define WB_ARB_RR_EN for round-robin, else fixed priority.
module wb_arbiter
    import wb_arb_pkg::NUM_REQ_DEF, wb_arb_pkg::PTR_W;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int XLEN       = wb_arb_pkg::XLEN,
    parameter int REG_ADDR_W = wb_arb_pkg::REG_ADDR_W
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][XLEN-1:0]        req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic                                write_enable,
    output logic [REG_ADDR_W-1:0]               write_addr,
    output logic [XLEN-1:0]                     write_data,
    output logic [15:0]                         write_cnt,
    output logic [15:0]                         zero_drop_cnt
);

    logic [NUM_REQ-1:0]    valid_q;
    logic [NUM_REQ-1:0]    grant;
    logic [PTR_W-1:0]      ptr;
    logic                  xfer;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [XLEN-1:0]       sel_data;

    // Reset and flush both mask requests before the picker, so grant is never raised.
    assign valid_q   = (reset || flush) ? '0 : req_valid;
    assign req_ready = grant;
    assign xfer      = |grant;

    wb_arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid (valid_q),
        .ptr   (ptr),
        .grant (grant)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i];
                sel_data = req_data[i];
            end
        end
    end

`ifdef WB_ARB_RR_EN
    logic [PTR_W-1:0] ptr_nxt;

    always_comb begin
        ptr_nxt = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) ptr_nxt = PTR_W'((i + 1) % NUM_REQ);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ptr <= '0;
        else       ptr <= ptr_nxt;
    end
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            write_enable  <= 1'b0;
            write_addr    <= '0;
            write_data    <= '0;
            write_cnt     <= '0;
            zero_drop_cnt <= '0;
        end else begin
            write_enable <= 1'b0;
            if (xfer) begin
                write_addr <= sel_addr;
                write_data <= sel_data;
                // x0 is hardwired: accept the write but never strobe the file.
                if (sel_addr != '0) begin
                    write_enable <= 1'b1;
                    write_cnt    <= write_cnt + 16'd1;
                end else begin
                    zero_drop_cnt <= zero_drop_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed rows push expectations, a negedge monitor checks.
module tb_wb_arbiter;
    import wb_arb_pkg::*;

    localparam int N = 3;
`ifdef WB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                        clk = 1'b0;
    logic                        reset = 1'b1;
    logic                        flush = 1'b0;
    logic [N-1:0]                req_valid = '0;
    logic [N-1:0][REG_ADDR_W-1:0] req_addr = '0;
    logic [N-1:0][XLEN-1:0]      req_data = '0;
    logic [N-1:0]                req_ready;
    logic                        write_enable;
    logic [REG_ADDR_W-1:0]       write_addr;
    logic [XLEN-1:0]             write_data;
    logic [15:0]                 write_cnt;
    logic [15:0]                 zero_drop_cnt;

    logic [REG_ADDR_W-1:0]       nxt_addr [N];
    logic [XLEN-1:0]             nxt_data [N];

    wb_arbiter #(.NUM_REQ(N), .XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .write_enable  (write_enable),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .write_cnt     (write_cnt),
        .zero_drop_cnt (zero_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           row;
        logic [N-1:0] rdy;
        logic         we;
        wb_req_t      wr;
        logic [15:0]  wc;
        logic [15:0]  zc;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   total = 0;
    int   bad   = 0;
    int   row   = 0;

    task automatic chk(string nm, int r, logic [63:0] act, logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s row %0d: got %0h want %0h", nm, r, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m = q.pop_front();
            chk("req_ready",     m.row, 64'(req_ready),     64'(m.rdy));
            chk("write_enable",  m.row, 64'(write_enable),  64'(m.we));
            chk("write_addr",    m.row, 64'(write_addr),    64'(m.wr.addr));
            chk("write_data",    m.row, 64'(write_data),    64'(m.wr.data));
            chk("write_cnt",     m.row, 64'(write_cnt),     64'(m.wc));
            chk("zero_drop_cnt", m.row, 64'(zero_drop_cnt), 64'(m.zc));
        end
    end

    task automatic drive(logic rst, logic fl, logic [N-1:0] v);
        @(posedge clk);
        #1;
        reset     = rst;
        flush     = fl;
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            req_addr[i] = nxt_addr[i];
            req_data[i] = nxt_data[i];
        end
    endtask

    // Expected write fields are what the output stage shows during this row.
    task automatic step(logic rst, logic fl, logic [N-1:0] v, logic [N-1:0] rdy,
                        logic we, logic [REG_ADDR_W-1:0] a, logic [XLEN-1:0] d,
                        logic [15:0] wc, logic [15:0] zc);
        exp_t e;
        drive(rst, fl, v);
        row++;
        e.row     = row;
        e.rdy     = rdy;
        e.we      = we;
        e.wr.addr = a;
        e.wr.data = d;
        e.wc      = wc;
        e.zc      = zc;
        q.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            nxt_addr[i] = '0;
            nxt_data[i] = '0;
        end
        repeat (2) @(posedge clk);

        // Reset release, idle
        for (int i = 0; i < 5; i++) step(0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0);

        // All requesting for 6 cycles
        nxt_addr[0] = 5'd1; nxt_data[0] = 32'h11;
        nxt_addr[1] = 5'd2; nxt_data[1] = 32'h22;
        nxt_addr[2] = 5'd3; nxt_data[2] = 32'h33;
        step(0, 0, 3'b111, 3'b001,              0, 0,             0,                0, 0);
        step(0, 0, 3'b111, RR ? 3'b010 : 3'b001, 1, 5'd1,          32'h11,           1, 0);
        step(0, 0, 3'b111, RR ? 3'b100 : 3'b001, 1, RR ? 5'd2 : 5'd1, RR ? 32'h22 : 32'h11, 2, 0);
        step(0, 0, 3'b111, 3'b001,              1, RR ? 5'd3 : 5'd1, RR ? 32'h33 : 32'h11, 3, 0);
        step(0, 0, 3'b111, RR ? 3'b010 : 3'b001, 1, 5'd1,          32'h11,           4, 0);
        step(0, 0, 3'b111, RR ? 3'b100 : 3'b001, 1, RR ? 5'd2 : 5'd1, RR ? 32'h22 : 32'h11, 5, 0);

        // Single request, addr 5
        nxt_addr[0] = 5'd5; nxt_data[0] = 32'hDEADBEEF;
        step(0, 0, 3'b001, 3'b001, 1, RR ? 5'd3 : 5'd1, RR ? 32'h33 : 32'h11, 6, 0);
        step(0, 0, 3'b000, 3'b000, 1, 5'd5, 32'hDEADBEEF, 7, 0);

        // Write to x0 is dropped
        nxt_addr[1] = 5'd0; nxt_data[1] = 32'h55;
        step(0, 0, 3'b010, 3'b010, 0, 5'd5, 32'hDEADBEEF, 7, 0);
        step(0, 0, 3'b000, 3'b000, 0, 5'd0, 32'h55,       7, 1);

        // Flush one cycle after a grant
        nxt_addr[2] = 5'd9; nxt_data[2] = 32'h99;
        step(0, 0, 3'b100, 3'b100, 0, 5'd0, 32'h55, 7, 1);
        step(0, 1, 3'b111, 3'b000, 1, 5'd9, 32'h99, 8, 1);
        step(0, 0, 3'b000, 3'b000, 0, 5'd9, 32'h99, 8, 1);

        // Reset with a pending request, then pointer must restart at 0
        step(1, 0, 3'b100, 3'b000, 0, 5'd9, 32'h99, 8, 1);
        step(0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0);
        step(0, 0, 3'b111, 3'b001, 0, 0, 0, 0, 0);
        step(0, 0, 3'b000, 3'b000, 1, 5'd5, 32'hDEADBEEF, 1, 0);

        // write_cnt wrap: 65535 more writes takes it from 1 to 0
        for (int i = 0; i < 65535; i++) drive(0, 0, 3'b001);
        step(0, 0, 3'b000, 3'b000, 1, 5'd5, 32'hDEADBEEF, 16'h0000, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
